// File: rtl/cti8_microsequencer.sv
`default_nettype none
// ============================================================================
// Module   : cti8_microsequencer
// Purpose  : Instruction register and 4-bit microstep counter feeding the
//            control unit decode inputs. Handles opcode fetch stalls,
//            halt/wake and interrupt injection at instruction boundaries.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            clk_en          - advance enable (all state holds when low)
//            mem_data        - opcode byte from memory bus
//            mem_ready       - memory read data valid this cycle
//            ir_load         - strobe: latch mem_data into instruction reg
//            step_reset      - strobe: end of instruction
//            halt            - strobe: enter halted state
//            irq             - level interrupt request
//            instruction     - current opcode
//            state           - current microstep
//            halted          - core halted
//            irq_ack         - one-cycle pulse when an interrupt is taken
//            step_fault      - sticky microstep counter overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module cti8_microsequencer #(
    parameter int         FETCH_STEPS  = 2,
    parameter logic [7:0] IRQ_OPCODE   = 8'hFF,
    parameter logic [7:0] RESET_OPCODE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [7:0] mem_data,
    input  logic       mem_ready,
    input  logic       ir_load,
    input  logic       step_reset,
    input  logic       halt,
    input  logic       irq,
    output logic [7:0] instruction,
    output logic [3:0] state,
    output logic       halted,
    output logic       irq_ack,
    output logic       step_fault
);

    // Run/halt mode encoding
    localparam logic [0:0] c_MODE_RUN  = 1'b0;
    localparam logic [0:0] c_MODE_HALT = 1'b1;

    // Interrupt entry skips the common fetch steps
    localparam logic [3:0] c_IRQ_STEP  = 4'(FETCH_STEPS);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [7:0] r_instruction;
    logic [3:0] r_state;
    logic [0:0] r_mode;
    logic       r_irq_ack;
    logic       r_step_fault;

    // ------------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------------
    logic [7:0] w_next_instruction;
    logic [3:0] w_next_state;
    logic [0:0] w_next_mode;
    logic       w_next_irq_ack;
    logic       w_next_step_fault;

    logic [3:0] w_state_inc;
    logic       w_state_carry;

    // Carry out of the 4-bit increment flags a wrap from step 15
    assign {w_state_carry, w_state_inc} = {1'b0, r_state} + 5'd1;

    always_comb begin
        w_next_instruction = r_instruction;
        w_next_state       = r_state;
        w_next_mode        = r_mode;
        w_next_irq_ack     = 1'b0;
        w_next_step_fault  = r_step_fault;

        case (r_mode)
            c_MODE_HALT: begin
                // Only an interrupt can wake the core; it is taken at once
                if (irq) begin
                    w_next_mode        = c_MODE_RUN;
                    w_next_instruction = IRQ_OPCODE;
                    w_next_state       = c_IRQ_STEP;
                    w_next_irq_ack     = 1'b1;
                end
            end
            default: begin
                if (halt) begin
                    w_next_mode = c_MODE_HALT;
                end else if (step_reset && irq) begin
                    w_next_instruction = IRQ_OPCODE;
                    w_next_state       = c_IRQ_STEP;
                    w_next_irq_ack     = 1'b1;
                end else if (step_reset) begin
                    w_next_state = 4'd0;
                end else if (ir_load && !mem_ready) begin
                    // Opcode fetch stall: wait for the memory bus
                    w_next_state = r_state;
                end else begin
                    if (ir_load) begin
                        w_next_instruction = mem_data;
                    end
                    w_next_state = w_state_inc;
                    if (w_state_carry) begin
                        w_next_step_fault = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instruction <= RESET_OPCODE;
            r_state       <= 4'd0;
            r_mode        <= c_MODE_RUN;
            r_irq_ack     <= 1'b0;
            r_step_fault  <= 1'b0;
        end else if (clk_en) begin
            r_instruction <= w_next_instruction;
            r_state       <= w_next_state;
            r_mode        <= w_next_mode;
            r_irq_ack     <= w_next_irq_ack;
            r_step_fault  <= w_next_step_fault;
        end else begin
            // The acknowledge is a pulse; never let it survive a stalled cycle
            r_irq_ack     <= 1'b0;
        end
    end

    assign instruction = r_instruction;
    assign state       = r_state;
    assign halted      = (r_mode == c_MODE_HALT);
    assign irq_ack     = r_irq_ack & clk_en;
    assign step_fault  = r_step_fault;

endmodule
`default_nettype wire

// File: tb/tb_cti8_microsequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cti8_microsequencer
// Purpose  : Directed self-checking bench for cti8_microsequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cti8_microsequencer;

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic [7:0] mem_data;
    logic       mem_ready;
    logic       ir_load;
    logic       step_reset;
    logic       halt;
    logic       irq;
    logic [7:0] instruction;
    logic [3:0] state;
    logic       halted;
    logic       irq_ack;
    logic       step_fault;

    int checks;
    int errors;

    cti8_microsequencer #(
        .FETCH_STEPS  (2),
        .IRQ_OPCODE   (8'hFF),
        .RESET_OPCODE (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .ir_load     (ir_load),
        .step_reset  (step_reset),
        .halt        (halt),
        .irq         (irq),
        .instruction (instruction),
        .state       (state),
        .halted      (halted),
        .irq_ack     (irq_ack),
        .step_fault  (step_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        ir_load    = 1'b0;
        step_reset = 1'b0;
        halt       = 1'b0;
        irq        = 1'b0;
        mem_ready  = 1'b0;
        mem_data   = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic expect_outputs(input string name, input logic [7:0] e_ins,
                                  input logic [3:0] e_st, input logic e_halt,
                                  input logic e_ack, input logic e_fault);
        checks++;
        if ({instruction, state, halted, irq_ack, step_fault} !==
            {e_ins, e_st, e_halt, e_ack, e_fault}) begin
            errors++;
            $display("FAIL %s: got ins=%02h st=%0d halted=%b ack=%b fault=%b, expected ins=%02h st=%0d halted=%b ack=%b fault=%b",
                     name, instruction, state, halted, irq_ack, step_fault,
                     e_ins, e_st, e_halt, e_ack, e_fault);
        end
    endtask

    task automatic test_reset();
        clk_en = 1'b1;
        clear_strobes();
        do_reset();
        expect_outputs("reset_values", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fetch_count();
        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_outputs($sformatf("count_step%0d", i), 8'h00, 4'(i), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        expect_outputs("stall_start", 8'h00, 4'd1, 1'b0, 1'b0, 1'b0);
        ir_load   = 1'b1;
        mem_ready = 1'b0;
        mem_data  = 8'h3A;
        tick();
        expect_outputs("stall_cycle1", 8'h00, 4'd1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_outputs("stall_cycle2", 8'h00, 4'd1, 1'b0, 1'b0, 1'b0);
        mem_ready = 1'b1;
        tick();
        expect_outputs("stall_load", 8'h3A, 4'd2, 1'b0, 1'b0, 1'b0);
        clear_strobes();
    endtask

    task automatic test_step_reset();
        tick();
        tick();
        expect_outputs("sr_at4", 8'h3A, 4'd4, 1'b0, 1'b0, 1'b0);
        step_reset = 1'b1;
        tick();
        expect_outputs("sr_no_irq", 8'h3A, 4'd0, 1'b0, 1'b0, 1'b0);
        step_reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        expect_outputs("sr_at4_again", 8'h3A, 4'd4, 1'b0, 1'b0, 1'b0);
        step_reset = 1'b1;
        irq        = 1'b1;
        tick();
        expect_outputs("sr_irq_entry", 8'hFF, 4'd2, 1'b0, 1'b1, 1'b0);
        clear_strobes();
        tick();
        expect_outputs("sr_ack_pulse_end", 8'hFF, 4'd3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_halt();
        // Load a distinct opcode so the wake-up injection is observable
        step_reset = 1'b1;
        tick();
        step_reset = 1'b0;
        ir_load    = 1'b1;
        mem_ready  = 1'b1;
        mem_data   = 8'h77;
        tick();
        clear_strobes();
        tick();
        tick();
        expect_outputs("halt_pre", 8'h77, 4'd3, 1'b0, 1'b0, 1'b0);
        halt       = 1'b1;
        step_reset = 1'b1;
        tick();
        expect_outputs("halt_enter", 8'h77, 4'd3, 1'b1, 1'b0, 1'b0);
        halt      = 1'b0;
        ir_load   = 1'b1;
        mem_ready = 1'b1;
        mem_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_outputs($sformatf("halt_hold%0d", i), 8'h77, 4'd3, 1'b1, 1'b0, 1'b0);
        end
        clear_strobes();
        irq = 1'b1;
        tick();
        expect_outputs("halt_wake_irq", 8'hFF, 4'd2, 1'b0, 1'b1, 1'b0);
        irq = 1'b0;
        tick();
        expect_outputs("halt_wake_after", 8'hFF, 4'd3, 1'b0, 1'b0, 1'b0);
        // halt also beats ir_load
        halt      = 1'b1;
        ir_load   = 1'b1;
        mem_ready = 1'b1;
        mem_data  = 8'h12;
        tick();
        expect_outputs("halt_over_load", 8'hFF, 4'd3, 1'b1, 1'b0, 1'b0);
        clear_strobes();
        do_reset();
        expect_outputs("reset_while_halted", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 15; i++) tick();
        expect_outputs("ovf_at15", 8'h00, 4'd15, 1'b0, 1'b0, 1'b0);
        tick();
        expect_outputs("ovf_wrap", 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_outputs("ovf_sticky", 8'h00, 4'd1, 1'b0, 1'b0, 1'b1);
        do_reset();
        expect_outputs("ovf_cleared", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        step_reset = 1'b1;
        tick();
        step_reset = 1'b0;
        expect_outputs("ovf_sr_at15", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_clk_en();
        tick();
        tick();
        expect_outputs("en_pre", 8'h00, 4'd2, 1'b0, 1'b0, 1'b0);
        clk_en     = 1'b0;
        irq        = 1'b1;
        step_reset = 1'b1;
        ir_load    = 1'b1;
        mem_ready  = 1'b1;
        mem_data   = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_outputs($sformatf("en_hold%0d", i), 8'h00, 4'd2, 1'b0, 1'b0, 1'b0);
        end
        clear_strobes();
        clk_en = 1'b1;
        tick();
        clk_en = 1'b0;
        expect_outputs("en_resume", 8'h00, 4'd3, 1'b0, 1'b0, 1'b0);
        do_reset();
        expect_outputs("en_reset_disabled", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        clk_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        // Interrupt entry immediately followed by another boundary with irq
        do_reset();
        step_reset = 1'b1;
        irq        = 1'b1;
        tick();
        expect_outputs("b2b_irq1", 8'hFF, 4'd2, 1'b0, 1'b1, 1'b0);
        tick();
        expect_outputs("b2b_irq2", 8'hFF, 4'd2, 1'b0, 1'b1, 1'b0);
        irq = 1'b0;
        tick();
        expect_outputs("b2b_sr", 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0);
        clear_strobes();
        // irq without step_reset must not be taken mid-instruction
        irq = 1'b1;
        tick();
        expect_outputs("irq_mid_instr", 8'hFF, 4'd1, 1'b0, 1'b0, 1'b0);
        clear_strobes();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        clk_en     = 1'b0;
        clear_strobes();
        tick();
        test_reset();
        test_fetch_count();
        test_stall();
        test_step_reset();
        test_halt();
        test_overflow();
        test_clk_en();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
